// File: rtl/key_encoder_if.sv
// Byte stream from the key encoder to the UART transmitter.
// The master presents data/valid and holds them until the slave raises ready.
interface key_encoder_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/key_encoder.sv
// Key events and identify requests to VT52 host-bound byte sequences.
// Optional: CAPS_LOCK_EN adds a caps-lock key and a-z upcasing.
module key_encoder #(
  parameter logic [7:0] KEY_BASE   = 8'h80,
  parameter logic [7:0] IDENT_CHAR = 8'h4B
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       ident_req,
  output logic       caps_on,
  key_encoder_if.master tx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_B0,
    S_B1,
    S_B2
  } state_t;

  state_t     r_state, n_state;
  logic [7:0] r_data, n_data;
  logic       r_valid, n_valid;
  logic [7:0] r_b1, n_b1;
  logic [7:0] r_b2, n_b2;
  logic [1:0] r_last, n_last;
  logic       r_pend, n_pend;

  logic [7:0] w_off;
  logic       w_plain;
  logic       w_arrow;
  logic       w_pf;
  logic [7:0] w_char;
  logic [1:0] w_idx;
  logic       w_start_id;

`ifdef CAPS_LOCK_EN
  logic       r_caps, n_caps;
  logic       w_capk;
  assign w_capk  = !w_plain && key_code >= KEY_BASE
                   && w_off == 8'd7;
  assign w_char  = (r_caps && key_code >= 8'h61
                    && key_code <= 8'h7A)
                   ? key_code - 8'h20 : key_code;
  assign caps_on = r_caps;
`else
  assign w_char  = key_code;
  assign caps_on = 1'b0;
`endif

  assign w_off   = key_code - KEY_BASE;
  assign w_plain = key_code < 8'h80;
  assign w_arrow = !w_plain && key_code >= KEY_BASE
                   && w_off < 8'd4;
  assign w_pf    = !w_plain && key_code >= KEY_BASE
                   && w_off >= 8'd4 && w_off < 8'd7;

  // Identify beats any key; key_ready drops on the request cycle itself.
  assign w_start_id = (r_state == S_IDLE)
                      && (r_pend || ident_req);
  assign key_ready  = (r_state == S_IDLE)
                      && !r_pend && !ident_req;

  assign tx.data  = r_data;
  assign tx.valid = r_valid;

  always_comb begin
    w_idx = 2'd0;
    unique case (r_state)
      S_B1:    w_idx = 2'd1;
      S_B2:    w_idx = 2'd2;
      default: w_idx = 2'd0;
    endcase
  end

  always_comb begin
    n_state = r_state;
    n_data  = r_data;
    n_valid = r_valid;
    n_b1    = r_b1;
    n_b2    = r_b2;
    n_last  = r_last;
    n_pend  = r_pend;
`ifdef CAPS_LOCK_EN
    n_caps  = r_caps;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_start_id) begin
          n_state = S_B0;
          n_valid = 1'b1;
          n_data  = 8'h1B;
          n_b1    = 8'h2F;
          n_b2    = IDENT_CHAR;
          n_last  = 2'd2;
        end else if (key_valid) begin
          unique case (1'b1)
            w_plain: begin
              n_state = S_B0;
              n_valid = 1'b1;
              n_data  = w_char;
              n_last  = 2'd0;
            end
            w_arrow: begin
              n_state = S_B0;
              n_valid = 1'b1;
              n_data  = 8'h1B;
              n_b1    = 8'h41 + w_off;
              n_last  = 2'd1;
            end
            w_pf: begin
              n_state = S_B0;
              n_valid = 1'b1;
              n_data  = 8'h1B;
              n_b1    = 8'h4C + w_off;
              n_last  = 2'd1;
            end
`ifdef CAPS_LOCK_EN
            w_capk: n_caps = !r_caps;
`endif
            default: ;
          endcase
        end
      end
      default: begin
        if (r_valid && tx.ready) begin
          if (w_idx == r_last) begin
            n_state = S_IDLE;
            n_valid = 1'b0;
          end else if (r_state == S_B0) begin
            n_state = S_B1;
            n_data  = r_b1;
          end else begin
            n_state = S_B2;
            n_data  = r_b2;
          end
        end
      end
    endcase
    if (w_start_id) n_pend = 1'b0;
    else if (ident_req) n_pend = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_b1    <= 8'h00;
      r_b2    <= 8'h00;
      r_last  <= 2'd0;
      r_pend  <= 1'b0;
`ifdef CAPS_LOCK_EN
      r_caps  <= 1'b0;
`endif
    end else begin
      r_state <= n_state;
      r_data  <= n_data;
      r_valid <= n_valid;
      r_b1    <= n_b1;
      r_b2    <= n_b2;
      r_last  <= n_last;
      r_pend  <= n_pend;
`ifdef CAPS_LOCK_EN
      r_caps  <= n_caps;
`endif
    end
  end

endmodule
